// File: rtl/haar_cascade_controller.sv
// Sequences the Haar cascade for one detection window: streams stage parameters from ROM,
// starts each stage, samples its verdict and reports face/reject. Optional stats: CASCADE_STATS_EN.
module haar_cascade_controller #(
  parameter int DATA_WIDTH_8             = 8,
  parameter int DATA_WIDTH_12            = 12,
  parameter int DATA_WIDTH_16            = 16,
  parameter int NUM_PARAM_PER_CLASSIFIER = 18,
  parameter int NUM_CLASSIFIERS          = 10,
  parameter int NUM_STAGE_THRESHOLD      = 1,
  parameter int NUM_STAGES               = 25,
  parameter int STAGE_LATENCY            = 4
) (
  input  logic                     clk_fpga,
  input  logic                     reset,
  input  logic                     i_window_valid,
  output logic                     o_window_ready,
  input  logic [DATA_WIDTH_12-1:0] i_window_x,
  input  logic [DATA_WIDTH_12-1:0] i_window_y,
  output logic                     o_rom_rd,
  output logic [DATA_WIDTH_16-1:0] o_rom_addr,
  input  logic [DATA_WIDTH_8-1:0]  i_rom_data,
  output logic                     o_param_wr,
  output logic [DATA_WIDTH_12-1:0] o_param_index,
  output logic [DATA_WIDTH_8-1:0]  o_param_data,
  output logic                     o_stage_start,
  input  logic                     i_iscandidate,
  output logic                     o_face_valid,
  output logic                     o_reject_valid,
  output logic [DATA_WIDTH_12-1:0] o_result_x,
  output logic [DATA_WIDTH_12-1:0] o_result_y,
  output logic [DATA_WIDTH_12-1:0] o_stage_index,
  output logic [DATA_WIDTH_16-1:0] o_window_count,
  output logic [DATA_WIDTH_16-1:0] o_face_count
);

  localparam int WORDS = NUM_CLASSIFIERS * NUM_PARAM_PER_CLASSIFIER + NUM_STAGE_THRESHOLD;
  localparam logic [DATA_WIDTH_16-1:0] WORDS_A    = DATA_WIDTH_16'(WORDS);
  localparam logic [DATA_WIDTH_12-1:0] WORDS_C    = DATA_WIDTH_12'(WORDS);
  localparam logic [DATA_WIDTH_12-1:0] LAST_STAGE = DATA_WIDTH_12'(NUM_STAGES - 1);
  localparam logic [DATA_WIDTH_12-1:0] LATENCY    = DATA_WIDTH_12'(STAGE_LATENCY);
  localparam logic [DATA_WIDTH_12-1:0] ONE        = DATA_WIDTH_12'(1);

  typedef enum logic [2:0] {IDLE, LOAD, EVAL, WAIT, REPORT} state_t;

  state_t                     state, state_nxt;
  logic [DATA_WIDTH_12-1:0]   cnt;
  logic [DATA_WIDTH_12-1:0]   wait_cnt;
  logic [DATA_WIDTH_12-1:0]   stage;
  logic [DATA_WIDTH_16-1:0]   base;
  logic                       is_face;
  logic [DATA_WIDTH_12-1:0]   win_x, win_y;
  logic                       last_sample;

  assign last_sample = (wait_cnt == ONE);

  // Window coordinates are pure data: captured on accept, no reset needed.
  always_ff @(posedge clk_fpga) begin
    if (state == IDLE && i_window_valid) begin
      win_x <= i_window_x;
      win_y <= i_window_y;
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      wait_cnt      <= '0;
      stage         <= '0;
      base          <= '0;
      is_face       <= 1'b0;
      o_result_x    <= '0;
      o_result_y    <= '0;
      o_stage_index <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (i_window_valid) begin
          stage <= '0;
          base  <= '0;
          cnt   <= '0;
        end
        LOAD: cnt <= cnt + ONE;
        EVAL: begin
          wait_cnt <= LATENCY;
          cnt      <= '0;
        end
        WAIT: begin
          wait_cnt <= wait_cnt - ONE;
          if (last_sample) begin
            if (!i_iscandidate || stage == LAST_STAGE) begin
              is_face       <= i_iscandidate;
              o_result_x    <= win_x;
              o_result_y    <= win_y;
              o_stage_index <= stage;
            end else begin
              stage <= stage + ONE;
              base  <= base + WORDS_A;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // LOAD runs WORDS+1 cycles: read k in cycle k, write k in cycle k+1.
  always_comb begin
    state_nxt      = state;
    o_window_ready = 1'b0;
    o_rom_rd       = 1'b0;
    o_rom_addr     = '0;
    o_param_wr     = 1'b0;
    o_param_index  = '0;
    o_param_data   = '0;
    o_stage_start  = 1'b0;
    o_face_valid   = 1'b0;
    o_reject_valid = 1'b0;
    case (state)
      IDLE: begin
        o_window_ready = 1'b1;
        if (i_window_valid) state_nxt = LOAD;
      end
      LOAD: begin
        if (cnt < WORDS_C) begin
          o_rom_rd   = 1'b1;
          o_rom_addr = base + DATA_WIDTH_16'(cnt);
        end
        if (cnt != '0) begin
          o_param_wr    = 1'b1;
          o_param_index = cnt - ONE;
          o_param_data  = i_rom_data;
        end
        if (cnt == WORDS_C) state_nxt = EVAL;
      end
      EVAL: begin
        o_stage_start = 1'b1;
        state_nxt     = WAIT;
      end
      WAIT: begin
        if (last_sample)
          state_nxt = (!i_iscandidate || stage == LAST_STAGE) ? REPORT : LOAD;
      end
      REPORT: begin
        o_face_valid   = is_face;
        o_reject_valid = !is_face;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef CASCADE_STATS_EN
  logic [DATA_WIDTH_16-1:0] window_count, face_count;

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      window_count <= '0;
      face_count   <= '0;
    end else if (state == REPORT) begin
      if (window_count != '1) window_count <= window_count + DATA_WIDTH_16'(1);
      if (is_face && face_count != '1) face_count <= face_count + DATA_WIDTH_16'(1);
    end
  end

  assign o_window_count = window_count;
  assign o_face_count   = face_count;
`else
  assign o_window_count = '0;
  assign o_face_count   = '0;
`endif

endmodule

// File: tb/tb_haar_cascade_controller.sv
// Directed bench for haar_cascade_controller: 2 classifiers, 3 stages, latency 4 (WORDS=37, P=43).
module tb_haar_cascade_controller;

  logic        clk_fpga = 1'b0;
  logic        reset = 1'b1;
  logic        i_window_valid = 1'b0;
  logic        o_window_ready;
  logic [11:0] i_window_x = '0;
  logic [11:0] i_window_y = '0;
  logic        o_rom_rd;
  logic [15:0] o_rom_addr;
  logic [7:0]  i_rom_data = '0;
  logic        o_param_wr;
  logic [11:0] o_param_index;
  logic [7:0]  o_param_data;
  logic        o_stage_start;
  logic        i_iscandidate;
  logic        o_face_valid;
  logic        o_reject_valid;
  logic [11:0] o_result_x;
  logic [11:0] o_result_y;
  logic [11:0] o_stage_index;
  logic [15:0] o_window_count;
  logic [15:0] o_face_count;

  int checks = 0;
  int errors = 0;
  int pass_count = 0;
  logic clr = 1'b0;

  int rd_cnt, wr_cnt, rd_bad, wr_bad, starts, start_bad, rep_cnt, both_cnt;
  int rd_max, wr_max;
  logic        prev_rd, prev_wr;
  logic [15:0] prev_addr;
  logic [11:0] prev_idx;

  haar_cascade_controller #(
    .NUM_CLASSIFIERS(2),
    .NUM_STAGES(3),
    .STAGE_LATENCY(4)
  ) dut (
    .clk_fpga(clk_fpga),
    .reset(reset),
    .i_window_valid(i_window_valid),
    .o_window_ready(o_window_ready),
    .i_window_x(i_window_x),
    .i_window_y(i_window_y),
    .o_rom_rd(o_rom_rd),
    .o_rom_addr(o_rom_addr),
    .i_rom_data(i_rom_data),
    .o_param_wr(o_param_wr),
    .o_param_index(o_param_index),
    .o_param_data(o_param_data),
    .o_stage_start(o_stage_start),
    .i_iscandidate(i_iscandidate),
    .o_face_valid(o_face_valid),
    .o_reject_valid(o_reject_valid),
    .o_result_x(o_result_x),
    .o_result_y(o_result_y),
    .o_stage_index(o_stage_index),
    .o_window_count(o_window_count),
    .o_face_count(o_face_count)
  );

  always #5 clk_fpga = ~clk_fpga;

  // ROM returns the low byte of the address, one cycle after the read.
  always @(posedge clk_fpga) if (o_rom_rd) i_rom_data <= o_rom_addr[7:0];

  // The first pass_count stages pass, the next one rejects.
  assign i_iscandidate = (starts <= pass_count);

  always @(negedge clk_fpga) begin
    if (clr) begin
      rd_cnt <= 0; wr_cnt <= 0; rd_bad <= 0; wr_bad <= 0; starts <= 0;
      start_bad <= 0; rep_cnt <= 0; both_cnt <= 0; rd_max <= -1; wr_max <= -1;
      prev_rd <= 1'b0; prev_wr <= 1'b0; prev_addr <= '0; prev_idx <= '0;
    end else if (reset) begin
      prev_rd <= 1'b0;
      prev_wr <= 1'b0;
    end else begin
      if (o_rom_rd) begin
        rd_cnt <= rd_cnt + 1;
        if (int'(o_rom_addr) > rd_max) rd_max <= int'(o_rom_addr);
        if (prev_rd && o_rom_addr != prev_addr + 16'd1) rd_bad <= rd_bad + 1;
      end
      if (o_param_wr) begin
        wr_cnt <= wr_cnt + 1;
        if (int'(o_param_index) > wr_max) wr_max <= int'(o_param_index);
        if (!prev_rd || o_param_data != prev_addr[7:0] ||
            int'(o_param_index) != int'(prev_addr) % 37)
          wr_bad <= wr_bad + 1;
      end
      if (o_stage_start) begin
        starts <= starts + 1;
        if (!(prev_wr && prev_idx == 12'd36)) start_bad <= start_bad + 1;
      end
      if (o_face_valid || o_reject_valid) rep_cnt <= rep_cnt + 1;
      if (o_face_valid && o_reject_valid) both_cnt <= both_cnt + 1;
      prev_rd   <= o_rom_rd;
      prev_addr <= o_rom_addr;
      prev_wr   <= o_param_wr;
      prev_idx  <= o_param_index;
    end
  end

  task automatic step();
    @(posedge clk_fpga);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // Offers a window in the current (idle) cycle T; lat is the cycle offset of the report.
  task automatic run_window(input logic [11:0] x, input logic [11:0] y, input int pass,
                            input bit hold, output int lat, output bit face, output bit rej);
    pass_count     = pass;
    i_window_x     = x;
    i_window_y     = y;
    i_window_valid = 1'b1;
    lat  = 0;
    face = 1'b0;
    rej  = 1'b0;
    while (lat < 400) begin
      step();
      lat++;
      if (!hold) i_window_valid = 1'b0;
      if (o_face_valid || o_reject_valid) begin
        face = o_face_valid;
        rej  = o_reject_valid;
        break;
      end
    end
    i_window_valid = 1'b0;
  endtask

  initial begin
    int  lat;
    bit  face, rej;

    clr = 1'b1;
    step();
    step();
    clr = 1'b0;
    chk("reset_ready", o_window_ready, 1);
    chk("reset_rd", o_rom_rd, 0);
    chk("reset_wr", o_param_wr, 0);
    chk("reset_start", o_stage_start, 0);
    chk("reset_face", o_face_valid, 0);
    chk("reset_reject", o_reject_valid, 0);
    chk("reset_result_x", o_result_x, 0);
    chk("reset_stage_index", o_stage_index, 0);
    chk("reset_window_count", o_window_count, 0);
    reset = 1'b0;
    step();

    // All stages pass: face after 3 periods.
    clear_stats();
    run_window(12'd5, 12'd9, 3, 1'b0, lat, face, rej);
    chk("face_latency", lat, 130);
    chk("face_valid", face, 1);
    chk("face_not_reject", rej, 0);
    chk("face_x", o_result_x, 5);
    chk("face_y", o_result_y, 9);
    chk("face_stage_index", o_stage_index, 2);
    step();
    chk("face_ready_after", o_window_ready, 1);
    chk("face_rd_count", rd_cnt, 111);
    chk("face_wr_count", wr_cnt, 111);
    chk("face_rd_max", rd_max, 110);
    chk("face_rd_seq", rd_bad, 0);
    chk("face_wr_data", wr_bad, 0);
    chk("face_starts", starts, 3);
    chk("face_start_timing", start_bad, 0);

    // Reject at stage 0.
    clear_stats();
    run_window(12'd100, 12'd200, 0, 1'b0, lat, face, rej);
    chk("rej0_latency", lat, 44);
    chk("rej0_reject", rej, 1);
    chk("rej0_not_face", face, 0);
    chk("rej0_stage_index", o_stage_index, 0);
    chk("rej0_x", o_result_x, 100);
    chk("rej0_y", o_result_y, 200);
    chk("rej0_rd_max", rd_max, 36);
    chk("rej0_rd_count", rd_cnt, 37);
    step();
    chk("rej0_ready_after", o_window_ready, 1);

    // Pass stage 0, reject at stage 1.
    clear_stats();
    run_window(12'd7, 12'd3, 1, 1'b0, lat, face, rej);
    chk("rej1_latency", lat, 87);
    chk("rej1_reject", rej, 1);
    chk("rej1_stage_index", o_stage_index, 1);
    chk("rej1_rd_max", rd_max, 73);
    chk("rej1_rd_count", rd_cnt, 74);
    chk("rej1_wr_count", wr_cnt, 74);
    chk("rej1_wr_max_index", wr_max, 36);
    chk("rej1_wr_data", wr_bad, 0);
    chk("rej1_starts", starts, 2);
    chk("rej1_start_timing", start_bad, 0);
    chk("rej1_both", both_cnt, 0);
    step();

    // Reset in the middle of stage-1 LOAD.
    clear_stats();
    pass_count     = 3;
    i_window_x     = 12'd11;
    i_window_y     = 12'd22;
    i_window_valid = 1'b1;
    step();
    i_window_valid = 1'b0;
    repeat (50) step();
    chk("mid_in_load", o_rom_rd, 1);
    reset = 1'b1;
    step();
    chk("mid_ready", o_window_ready, 1);
    chk("mid_rd", o_rom_rd, 0);
    chk("mid_wr", o_param_wr, 0);
    chk("mid_start", o_stage_start, 0);
    chk("mid_face", o_face_valid, 0);
    chk("mid_reject", o_reject_valid, 0);
    reset = 1'b0;
    repeat (200) step();
    chk("mid_no_report", rep_cnt, 0);
    chk("mid_idle_ready", o_window_ready, 1);

    // Face, reject, face after reset; the last one holds valid high throughout.
    clear_stats();
    run_window(12'd1, 12'd2, 3, 1'b0, lat, face, rej);
    chk("post_face_latency", lat, 130);
    chk("post_face_valid", face, 1);
    chk("post_face_x", o_result_x, 1);
    step();
    clear_stats();
    run_window(12'd4, 12'd4, 0, 1'b0, lat, face, rej);
    chk("post_rej_latency", lat, 44);
    chk("post_rej_valid", rej, 1);
    step();
    clear_stats();
    run_window(12'd8, 12'd6, 3, 1'b1, lat, face, rej);
    chk("hold_face_latency", lat, 130);
    chk("hold_face_valid", face, 1);
    chk("hold_single_accept", starts, 3);
    chk("hold_y", o_result_y, 6);
    step();
    chk("hold_ready_after", o_window_ready, 1);
    step();
    chk("hold_ready_stays", o_window_ready, 1);
    chk("hold_no_rd", o_rom_rd, 0);
`ifdef CASCADE_STATS_EN
    chk("stats_window_count", o_window_count, 3);
    chk("stats_face_count", o_face_count, 2);
`else
    chk("stats_window_count_off", o_window_count, 0);
    chk("stats_face_count_off", o_face_count, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
